// File: rtl/regfile_sb_if.sv
// Bundle of read, write, issue and debug signals between the pipeline and regfile_sb.
// The master modport is the pipeline side; the slave modport is the register file.
interface regfile_sb_if #(
  parameter int DW  = 32,
  parameter int AW  = 5,
  parameter int NRD = 2
);
  logic [NRD*AW-1:0] rd_addr;
  logic [NRD*DW-1:0] rd_data;
  logic [NRD-1:0]    rd_busy;
  logic              wa_en;
  logic [AW-1:0]     wa_addr;
  logic [DW-1:0]     wa_data;
  logic              wb_en;
  logic [AW-1:0]     wb_addr;
  logic [DW-1:0]     wb_data;
  logic              iss_en;
  logic [AW-1:0]     iss_addr;
  logic [AW-1:0]     dbg_addr;
  logic [DW-1:0]     dbg_data;
  logic [AW:0]       busy_cnt;

  modport master (
    output rd_addr, wa_en, wa_addr, wa_data, wb_en, wb_addr, wb_data,
           iss_en, iss_addr, dbg_addr,
    input  rd_data, rd_busy, dbg_data, busy_cnt
  );

  modport slave (
    input  rd_addr, wa_en, wa_addr, wa_data, wb_en, wb_addr, wb_data,
           iss_en, iss_addr, dbg_addr,
    output rd_data, rd_busy, dbg_data, busy_cnt
  );
endinterface

// File: rtl/regfile_sb.sv
// ID-stage register file: NRD combinational read ports with optional write bypass,
// two write ports (A has priority), a pending-write scoreboard and a registered debug port.
module regfile_sb #(
  parameter int DW     = 32,
  parameter int AW     = 5,
  parameter int NRD    = 2,
  parameter int BYPASS = 1
) (
  input logic         clk,
  input logic         rst,
  regfile_sb_if.slave bus
);
  localparam int DEPTH = 2**AW;

  logic [DW-1:0]     mem [DEPTH];
  logic [DEPTH-1:0]  busy;
  logic [DEPTH-1:0]  busy_next;
  logic [AW:0]       cnt_next;
  logic [AW:0]       cnt_q;
  logic [DW-1:0]     dbg_q;
  logic [NRD*DW-1:0] rd_data_c;
  logic [NRD-1:0]    rd_busy_c;
  logic              wa_ok;
  logic              wb_hit;
  logic              wb_ok;
  logic              iss_ok;
  logic [AW-1:0]     ra;
  logic [DW-1:0]     rv;
  logic              rb;
  logic              wr_hit;

  // A dropped port-B write (same address as A) still counts as a write for the scoreboard.
  assign wa_ok  = bus.wa_en && (bus.wa_addr != '0);
  assign wb_hit = bus.wb_en && (bus.wb_addr != '0);
  assign wb_ok  = wb_hit && !(wa_ok && (bus.wa_addr == bus.wb_addr));
  assign iss_ok = bus.iss_en && (bus.iss_addr != '0);

  always_comb begin
    busy_next = busy;
    if (wa_ok)  busy_next[bus.wa_addr]  = 1'b0;
    if (wb_hit) busy_next[bus.wb_addr]  = 1'b0;
    if (iss_ok) busy_next[bus.iss_addr] = 1'b1;
    cnt_next = '0;
    for (int i = 0; i < DEPTH; i++) begin
      cnt_next = cnt_next + (AW+1)'(busy_next[i]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (wa_ok) mem[bus.wa_addr] <= bus.wa_data;
      if (wb_ok) mem[bus.wb_addr] <= bus.wb_data;
    end
  end

  // Debug port samples the stored array only, so a same-edge write shows up a cycle later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy  <= '0;
      cnt_q <= '0;
      dbg_q <= '0;
    end else begin
      busy  <= busy_next;
      cnt_q <= cnt_next;
      dbg_q <= (bus.dbg_addr == '0) ? '0 : mem[bus.dbg_addr];
    end
  end

  always_comb begin
    rd_data_c = '0;
    rd_busy_c = '0;
    ra        = '0;
    rv        = '0;
    rb        = 1'b0;
    wr_hit    = 1'b0;
    for (int k = 0; k < NRD; k++) begin
      ra     = bus.rd_addr[k*AW +: AW];
      wr_hit = (bus.wa_en && (bus.wa_addr == ra)) || (bus.wb_en && (bus.wb_addr == ra));
      rv     = mem[ra];
      rb     = busy[ra];
      if (BYPASS != 0) begin
        if (bus.wa_en && (bus.wa_addr == ra))      rv = bus.wa_data;
        else if (bus.wb_en && (bus.wb_addr == ra)) rv = bus.wb_data;
        rb = rb & ~wr_hit;
      end
      if (ra == '0) begin
        rv = '0;
        rb = 1'b0;
      end
      rd_data_c[k*DW +: DW] = rv;
      rd_busy_c[k]          = rb;
    end
  end

  assign bus.rd_data  = rd_data_c;
  assign bus.rd_busy  = rd_busy_c;
  assign bus.dbg_data = dbg_q;
  assign bus.busy_cnt = cnt_q;
endmodule

// File: tb/tb_regfile_sb.sv
// Drives a BYPASS=1 and a BYPASS=0 regfile_sb with identical stimulus and checks both
// against a directed vector table and an array-based model of the register-file rules.
module tb_regfile_sb;
  localparam int DW  = 32;
  localparam int AW  = 5;
  localparam int NRD = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  regfile_sb_if #(.DW(DW), .AW(AW), .NRD(NRD)) if1 ();
  regfile_sb_if #(.DW(DW), .AW(AW), .NRD(NRD)) if0 ();

  assign if0.rd_addr  = if1.rd_addr;
  assign if0.wa_en    = if1.wa_en;
  assign if0.wa_addr  = if1.wa_addr;
  assign if0.wa_data  = if1.wa_data;
  assign if0.wb_en    = if1.wb_en;
  assign if0.wb_addr  = if1.wb_addr;
  assign if0.wb_data  = if1.wb_data;
  assign if0.iss_en   = if1.iss_en;
  assign if0.iss_addr = if1.iss_addr;
  assign if0.dbg_addr = if1.dbg_addr;

  regfile_sb #(.DW(DW), .AW(AW), .NRD(NRD), .BYPASS(1)) u_dut_byp (
    .clk(clk), .rst(rst), .bus(if1.slave)
  );
  regfile_sb #(.DW(DW), .AW(AW), .NRD(NRD), .BYPASS(0)) u_dut_nobyp (
    .clk(clk), .rst(rst), .bus(if0.slave)
  );

  typedef struct {
    logic        wa_en;
    logic [4:0]  wa_addr;
    logic [31:0] wa_data;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        iss_en;
    logic [4:0]  iss_addr;
    logic [4:0]  rd0;
    logic [4:0]  dbg;
    logic [31:0] exp_rd_b1;
    logic [31:0] exp_rd_b0;
    logic        exp_busy_b1;
    logic        exp_busy_b0;
    logic [5:0]  exp_cnt;
    logic [31:0] exp_dbg;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] m_reg [32];
  bit          m_busy [32];
  logic [31:0] m_dbg;
  int          m_cnt;

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic apply_stimulus(input vec_t v, input logic [4:0] rd1);
    if1.wa_en    = v.wa_en;
    if1.wa_addr  = v.wa_addr;
    if1.wa_data  = v.wa_data;
    if1.wb_en    = v.wb_en;
    if1.wb_addr  = v.wb_addr;
    if1.wb_data  = v.wb_data;
    if1.iss_en   = v.iss_en;
    if1.iss_addr = v.iss_addr;
    if1.rd_addr  = {rd1, v.rd0};
    if1.dbg_addr = v.dbg;
  endtask

  function automatic logic written_now(input logic [4:0] a);
    return (if1.wa_en && if1.wa_addr == a) || (if1.wb_en && if1.wb_addr == a);
  endfunction

  function automatic logic [31:0] model_rd(input bit byp, input logic [4:0] a);
    if (a == 0) return 32'h0;
    if (byp && if1.wa_en && if1.wa_addr == a) return if1.wa_data;
    if (byp && if1.wb_en && if1.wb_addr == a) return if1.wb_data;
    return m_reg[a];
  endfunction

  function automatic logic model_busy(input bit byp, input logic [4:0] a);
    if (a == 0) return 1'b0;
    return m_busy[a] && !(byp && written_now(a));
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m_reg[i]  = 32'h0;
      m_busy[i] = 1'b0;
    end
    m_dbg = 32'h0;
    m_cnt = 0;
  endtask

  // Advance the model past the upcoming rising edge using the inputs now on the bus.
  task automatic model_update();
    m_dbg = m_reg[if1.dbg_addr];
    if (if1.wa_en && if1.wa_addr != 0) m_reg[if1.wa_addr] = if1.wa_data;
    if (if1.wb_en && if1.wb_addr != 0 && !(if1.wa_en && if1.wa_addr == if1.wb_addr))
      m_reg[if1.wb_addr] = if1.wb_data;
    if (if1.wa_en) m_busy[if1.wa_addr] = 1'b0;
    if (if1.wb_en) m_busy[if1.wb_addr] = 1'b0;
    if (if1.iss_en) m_busy[if1.iss_addr] = 1'b1;
    m_busy[0] = 1'b0;
    m_cnt = 0;
    for (int i = 0; i < 32; i++) m_cnt += int'(m_busy[i]);
  endtask

  task automatic check_model();
    logic [4:0] a;
    for (int k = 0; k < NRD; k++) begin
      a = if1.rd_addr[k*AW +: AW];
      check_output($sformatf("rd_data byp1 port%0d addr%0d", k, a), 64'(if1.rd_data[k*DW +: DW]), 64'(model_rd(1'b1, a)));
      check_output($sformatf("rd_data byp0 port%0d addr%0d", k, a), 64'(if0.rd_data[k*DW +: DW]), 64'(model_rd(1'b0, a)));
      check_output($sformatf("rd_busy byp1 port%0d addr%0d", k, a), 64'(if1.rd_busy[k]), 64'(model_busy(1'b1, a)));
      check_output($sformatf("rd_busy byp0 port%0d addr%0d", k, a), 64'(if0.rd_busy[k]), 64'(model_busy(1'b0, a)));
    end
    check_output("dbg_data byp1", 64'(if1.dbg_data), 64'(m_dbg));
    check_output("dbg_data byp0", 64'(if0.dbg_data), 64'(m_dbg));
    check_output("busy_cnt byp1", 64'(if1.busy_cnt), 64'(m_cnt));
    check_output("busy_cnt byp0", 64'(if0.busy_cnt), 64'(m_cnt));
  endtask

  vec_t idle;
  vec_t vt [14];
  vec_t rv;

  initial begin
    idle = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0,
             32'h0, 32'h0, 1'b0, 1'b0, 6'd0, 32'h0};
    // wa_en,wa_a,wa_d, wb_en,wb_a,wb_d, iss_en,iss_a, rd0,dbg, rd_b1,rd_b0, bsy_b1,bsy_b0, cnt, dbg
    vt[0]  = '{1, 5, 32'h1234,     1, 5, 32'hBEEF, 0, 0, 5, 5, 32'h1234, 32'h0,    0, 0, 0, 32'h0};
    vt[1]  = '{0, 0, 32'h0,        0, 0, 32'h0,    0, 0, 5, 5, 32'h1234, 32'h1234, 0, 0, 0, 32'h0};
    vt[2]  = '{1, 0, 32'hFFFFFFFF, 0, 0, 32'h0,    0, 0, 0, 5, 32'h0,    32'h0,    0, 0, 0, 32'h1234};
    vt[3]  = '{0, 0, 32'h0,        0, 0, 32'h0,    1, 0, 0, 0, 32'h0,    32'h0,    0, 0, 0, 32'h1234};
    vt[4]  = '{0, 0, 32'h0,        0, 0, 32'h0,    1, 3, 3, 0, 32'h0,    32'h0,    0, 0, 0, 32'h0};
    vt[5]  = '{0, 0, 32'h0,        0, 0, 32'h0,    0, 0, 3, 0, 32'h0,    32'h0,    1, 1, 1, 32'h0};
    vt[6]  = '{0, 0, 32'h0,        1, 3, 32'h7,    0, 0, 3, 0, 32'h7,    32'h0,    0, 1, 1, 32'h0};
    vt[7]  = '{0, 0, 32'h0,        0, 0, 32'h0,    0, 0, 3, 0, 32'h7,    32'h7,    0, 0, 0, 32'h0};
    vt[8]  = '{1, 9, 32'hA5A5,     0, 0, 32'h0,    1, 9, 9, 9, 32'hA5A5, 32'h0,    0, 0, 0, 32'h0};
    vt[9]  = '{0, 0, 32'h0,        0, 0, 32'h0,    0, 0, 9, 9, 32'hA5A5, 32'hA5A5, 1, 1, 1, 32'h0};
    vt[10] = '{0, 0, 32'h0,        0, 0, 32'h0,    0, 0, 9, 9, 32'hA5A5, 32'hA5A5, 1, 1, 1, 32'hA5A5};
    vt[11] = '{1, 2, 32'h55,       0, 0, 32'h0,    0, 0, 2, 2, 32'h55,   32'h0,    0, 0, 1, 32'hA5A5};
    vt[12] = '{0, 0, 32'h0,        0, 0, 32'h0,    0, 0, 2, 2, 32'h55,   32'h55,   0, 0, 1, 32'h0};
    vt[13] = '{0, 0, 32'h0,        0, 0, 32'h0,    0, 0, 2, 2, 32'h55,   32'h55,   0, 0, 1, 32'h55};

    apply_stimulus(idle, 5'd0);
    model_reset();
    repeat (2) @(negedge clk);
    #2 check_model();
    rst = 1'b0;

    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      apply_stimulus(vt[i], 5'd0);
      #2;
      check_output($sformatf("vec%0d rd_data byp1", i), 64'(if1.rd_data[DW-1:0]), 64'(vt[i].exp_rd_b1));
      check_output($sformatf("vec%0d rd_data byp0", i), 64'(if0.rd_data[DW-1:0]), 64'(vt[i].exp_rd_b0));
      check_output($sformatf("vec%0d rd_busy byp1", i), 64'(if1.rd_busy[0]), 64'(vt[i].exp_busy_b1));
      check_output($sformatf("vec%0d rd_busy byp0", i), 64'(if0.rd_busy[0]), 64'(vt[i].exp_busy_b0));
      check_output($sformatf("vec%0d busy_cnt", i), 64'(if1.busy_cnt), 64'(vt[i].exp_cnt));
      check_output($sformatf("vec%0d dbg_data", i), 64'(if0.dbg_data), 64'(vt[i].exp_dbg));
      check_model();
      model_update();
    end

    // Random traffic; narrow address range forces port collisions and issue/write overlaps.
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      rv = idle;
      rv.wa_en    = ($urandom_range(0, 2) == 0);
      rv.wa_addr  = 5'($urandom_range(0, (i % 4 == 0) ? 31 : 7));
      rv.wa_data  = $urandom;
      rv.wb_en    = ($urandom_range(0, 2) == 0);
      rv.wb_addr  = 5'($urandom_range(0, 7));
      rv.wb_data  = $urandom;
      rv.iss_en   = ($urandom_range(0, 1) == 0);
      rv.iss_addr = 5'($urandom_range(0, (i % 3 == 0) ? 31 : 7));
      rv.rd0      = 5'($urandom_range(0, 7));
      rv.dbg      = 5'($urandom_range(0, 7));
      apply_stimulus(rv, 5'($urandom_range(0, 31)));
      #2 check_model();
      model_update();
    end

    // Asynchronous reset with no clock edge in between.
    @(negedge clk);
    rv = idle;
    rv.rd0 = 5'($urandom_range(1, 7));
    apply_stimulus(rv, 5'($urandom_range(1, 7)));
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_model();
    for (int k = 0; k < NRD; k++) begin
      check_output($sformatf("reset rd_data port%0d", k), 64'(if1.rd_data[k*DW +: DW]), 64'h0);
    end
    check_output("reset busy_cnt", 64'(if1.busy_cnt), 64'h0);
    check_output("reset dbg_data", 64'(if1.dbg_data), 64'h0);
    #1 rst = 1'b0;

    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      rv = idle;
      rv.wa_en    = ($urandom_range(0, 1) == 0);
      rv.wa_addr  = 5'($urandom_range(0, 7));
      rv.wa_data  = $urandom;
      rv.wb_en    = ($urandom_range(0, 1) == 0);
      rv.wb_addr  = 5'($urandom_range(0, 7));
      rv.wb_data  = $urandom;
      rv.iss_en   = ($urandom_range(0, 1) == 0);
      rv.iss_addr = 5'($urandom_range(0, 7));
      rv.rd0      = 5'($urandom_range(0, 7));
      rv.dbg      = 5'($urandom_range(0, 7));
      apply_stimulus(rv, 5'($urandom_range(0, 7)));
      #2 check_model();
      model_update();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
